job_seq_arbiter: RTL

Merges the 64-bit packed sequence streams of `NUM_LANES` parallel match-engine lanes into one ordered output stream. Each lane carries whole jobs; jobs were dispatched round-robin, so the arbiter grants one lane at a time and holds that grant until the lane emits its end-of-job beat. A job delimiter returns the grant to lane 0 for the next stream. The block sits between the per-lane sequence packers and the sequence encoder.

---
 rtl/job_seq_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/job_seq_arbiter.sv
// job_seq_arbiter
// Merges the packed 64-bit sequence streams of NUM_LANES match-engine lanes
// into one ordered stream. A single lane is granted at a time and keeps the
// grant until it emits an end-of-job beat; a delimiter on that beat returns
// the grant to lane 0 so the next stream starts from the first lane.
module job_seq_arbiter #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = $clog2(NUM_LANES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_LANES-1:0]    input_valid,
   input  logic [64*NUM_LANES-1:0] input_seq,
   input  logic [NUM_LANES-1:0]    input_end_of_job,
   input  logic [NUM_LANES-1:0]    input_delim,
   output logic [NUM_LANES-1:0]    input_ready,
   output logic                    output_valid,
   output logic [63:0]             output_seq,
   output logic                    output_end_of_job,
   output logic                    output_delim,
   output logic [LANE_W-1:0]       output_lane,
   input  logic                    output_ready,
   output logic [31:0]             jobs_done
);

   logic [LANE_W-1:0] cur_lane_q, cur_lane_d;
   logic              out_valid_q;
   logic [63:0]       out_seq_q;
   logic              out_eoj_q;
   logic              out_delim_q;
   logic [LANE_W-1:0] out_lane_q;
   logic [31:0]       jobs_done_q, jobs_done_d;

   logic              load;
   logic              accept;
   logic [63:0]       sel_seq;
   logic              sel_eoj;
   logic              sel_delim;

   // Lane select, handshake and next-state for grant and job counter.
   // Ready only looks at the output register and the grant, never at any
   // lane's valid, so upstream can't form a combinational loop through us.
   always_comb begin
      load      = !out_valid_q || output_ready;
      sel_seq   = input_seq[{cur_lane_q, 6'b0} +: 64];
      sel_eoj   = input_end_of_job[cur_lane_q];
      // A delimiter without end-of-job carries no meaning and is dropped.
      sel_delim = input_delim[cur_lane_q] && sel_eoj;
      accept    = input_valid[cur_lane_q] && load;

      input_ready = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         input_ready[i] = load && (cur_lane_q == LANE_W'(i));
      end

      cur_lane_d  = cur_lane_q;
      jobs_done_d = jobs_done_q;
      if (accept && sel_eoj) begin
         // Power-of-two lane count: the natural wrap of the index is modulo NUM_LANES.
         cur_lane_d  = sel_delim ? '0 : cur_lane_q + LANE_W'(1);
         jobs_done_d = jobs_done_q + 32'd1;
      end
   end

   // Grant register: advances only on an accepted end-of-job beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_lane_q <= '0;
      end else begin
         cur_lane_q <= cur_lane_d;
      end
   end

   // Completed-job counter; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jobs_done_q <= '0;
      end else if (accept && sel_eoj) begin
         jobs_done_q <= jobs_done_d;
      end
   end

   // Output register: loads on accept, empties when drained with nothing new,
   // otherwise holds its contents while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_seq_q   <= '0;
         out_eoj_q   <= 1'b0;
         out_delim_q <= 1'b0;
         out_lane_q  <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_seq_q   <= sel_seq;
         out_eoj_q   <= sel_eoj;
         out_delim_q <= sel_delim;
         out_lane_q  <= cur_lane_q;
      end else if (output_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign output_valid      = out_valid_q;
   assign output_seq        = out_seq_q;
   assign output_end_of_job = out_eoj_q;
   assign output_delim      = out_delim_q;
   assign output_lane       = out_lane_q;
   assign jobs_done         = jobs_done_q;

endmodule
